// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receive word packer.
package uart_rx_pkg;
  typedef enum logic {EMPTY, FILL} acc_state_e;
  localparam int BYTES_PER_WORD = 4;
  localparam int TIMEOUT_CYC_DEF = 43400;
endpackage

// File: rtl/uart_rx_timeout.sv
// uart_rx_timeout: idle counter that pulses expire after TIMEOUT_CYC enabled cycles.
module uart_rx_timeout
  import uart_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [TO_W-1:0] cnt_q, cnt_d;
  // clr has priority so a byte arriving on the expiry cycle wins over the flush
  assign expire = en & ~clr & (cnt_q == TO_W'(TIMEOUT_CYC - 1));
  always_comb cnt_d = (clr | ~en | expire) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_rx_pack.sv
// uart_rx_pack: packs received UART bytes into 32-bit RX FIFO words; optional UART_RX_ERR_DROP_EN drops fe/pe bytes.
module uart_rx_pack
  import uart_rx_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int TO_W        = 16
) (
  input  logic        clock_125,
  input  logic        rst_125,
  input  logic        rx_en,
  input  logic        uart_rxvld,
  input  logic [7:0]  uart_rxdata,
  input  logic        ne_flag,
  input  logic        fe_flag,
  input  logic        pe_flag,
  input  logic        uart_rxfifo_full,
  output logic        uart_rxfifo_wren,
  output logic [31:0] uart_rxfifo_data,
  output logic [2:0]  uart_rxfifo_bcnt,
  input  logic        rx_ovr_clr,
  output logic        rx_ovr_err,
  output logic [7:0]  rx_err_cnt
);
  acc_state_e  state_q, state_d;
  logic [31:0] acc_q, acc_d, hold_q, hold_d, acc_wr;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  hcnt_q, hcnt_d;
  logic        pend_q, pend_d, ovr_q, ovr_d;
  logic        bad, accept, complete, expire, xfer, hold_free;
  logic        unused_flags;
`ifdef UART_RX_ERR_DROP_EN
  logic [7:0]  errc_q, errc_d;
  assign bad = fe_flag | pe_flag;
  assign unused_flags = ne_flag;
  always_comb errc_d = rx_ovr_clr ? 8'd0 :
                       (uart_rxvld & rx_en & bad & (errc_q != 8'hFF)) ? errc_q + 8'd1 : errc_q;
  always_ff @(posedge clock_125) errc_q <= rst_125 ? 8'd0 : errc_d;
  assign rx_err_cnt = errc_q;
`else
  assign bad = 1'b0;
  assign unused_flags = ^{ne_flag, fe_flag, pe_flag};
  assign rx_err_cnt = 8'd0;
`endif
  assign accept    = uart_rxvld & rx_en & ~bad;
  assign complete  = accept & (idx_q == 2'(BYTES_PER_WORD - 1));
  assign xfer      = complete | expire;
  assign acc_wr    = acc_q | ({24'd0, accept ? uart_rxdata : 8'd0} << {idx_q, 3'b000});
  assign hold_free = ~pend_q | ~uart_rxfifo_full;
  assign uart_rxfifo_wren = pend_q & ~uart_rxfifo_full & ~rst_125;
  assign uart_rxfifo_data = hold_q;
  assign uart_rxfifo_bcnt = hcnt_q;
  assign rx_ovr_err       = ovr_q;
  uart_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC), .TO_W(TO_W)) u_timeout (
    .clk    (clock_125),
    .rst    (rst_125),
    .clr    (accept | ~rx_en),
    .en     (state_q == FILL),
    .expire (expire)
  );
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    pend_d  = uart_rxfifo_wren ? 1'b0 : pend_q;
    ovr_d   = rx_ovr_clr ? 1'b0 : ovr_q;
    if (!rx_en) begin
      state_d = EMPTY;
      acc_d   = '0;
      idx_d   = '0;
    end else if (xfer) begin
      state_d = EMPTY;
      acc_d   = '0;
      idx_d   = '0;
      // HOLD reloads when empty or draining this cycle; otherwise the new word is lost
      if (hold_free) begin
        hold_d = acc_wr;
        hcnt_d = complete ? 3'd4 : {1'b0, idx_q};
        pend_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (accept) begin
      state_d = FILL;
      acc_d   = acc_wr;
      idx_d   = idx_q + 2'd1;
    end
  end
  always_ff @(posedge clock_125) begin
    if (rst_125) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_pack.sv
// tb_uart_rx_pack: directed plus random stimulus against a byte-queue reference model.
module tb_uart_rx_pack;
  localparam int T = 24;
  logic        clk = 1'b0;
  logic        rst, rx_en, vld, ne, fe, pe, full, clr;
  logic [7:0]  rxd;
  logic        wren, ovr;
  logic [31:0] data;
  logic [2:0]  bcnt;
  logic [7:0]  errc;
  always #4 clk = ~clk;
  uart_rx_pack #(.TIMEOUT_CYC(T), .TO_W(8)) dut (
    .clock_125(clk), .rst_125(rst), .rx_en(rx_en), .uart_rxvld(vld), .uart_rxdata(rxd),
    .ne_flag(ne), .fe_flag(fe), .pe_flag(pe), .uart_rxfifo_full(full),
    .uart_rxfifo_wren(wren), .uart_rxfifo_data(data), .uart_rxfifo_bcnt(bcnt),
    .rx_ovr_clr(clr), .rx_ovr_err(ovr), .rx_err_cnt(errc)
  );
  int n_cmp = 0, n_bad = 0;
  logic [7:0]  mq[$];
  int          cyc = 0, last = 0, m_cnt = 0, m_err = 0;
  bit          m_pend = 0, m_ovr = 0;
  logic [31:0] m_hold = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic step(input bit v, input logic [7:0] b, input bit f_fe, input bit f_pe, input bit f_ne,
                      input bit f_full, input bit en, input bit c, input bit r);
    bit exp_wr, bad, acc, flush, ovr_set;
    logic [31:0] word;
    int nb;
    vld = v; rxd = b; fe = f_fe; pe = f_pe; ne = f_ne; full = f_full; rx_en = en; clr = c; rst = r;
    #1;
    exp_wr = m_pend && !f_full && !r;
    check("wren", wren, exp_wr);
    check("data", data, m_hold);
    check("bcnt", bcnt, m_cnt);
    check("ovr", ovr, m_ovr);
    check("errcnt", errc, m_err);
    if (r) begin
      mq.delete(); m_pend = 0; m_hold = 0; m_cnt = 0; m_ovr = 0; m_err = 0;
    end else begin
      bad = 0;
`ifdef UART_RX_ERR_DROP_EN
      bad = f_fe | f_pe;
`endif
      acc = v && en && !bad;
      flush = 0; ovr_set = 0;
      if (!en) mq.delete();
      else if (acc) begin
        mq.push_back(b);
        last = cyc;
        flush = (mq.size() == 4);
      end else if (mq.size() > 0 && cyc - last == T) flush = 1;
      if (flush) begin
        word = 0;
        foreach (mq[i]) word |= 32'(mq[i]) << (8 * i);
        nb = mq.size();
        mq.delete();
        if (m_pend && f_full) ovr_set = 1;
        else begin m_hold = word; m_cnt = nb; m_pend = 1; end
      end else if (exp_wr) m_pend = 0;
      m_ovr = ovr_set ? 1'b1 : c ? 1'b0 : m_ovr;
`ifdef UART_RX_ERR_DROP_EN
      if (c) m_err = 0;
      else if (v && en && bad && m_err < 255) m_err++;
`endif
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic put(input logic [7:0] b, input bit f_full);
    step(1, b, 0, 0, 0, f_full, 1, 0, 0);
  endtask
  task automatic idle(input int n, input bit f_full);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, f_full, 1, 0, 0);
  endtask
  initial begin
    bit rf;
    rst = 1; rx_en = 0; vld = 0; rxd = 0; ne = 0; fe = 0; pe = 0; full = 0; clr = 0;
    @(negedge clk); @(negedge clk);
    step(0, 8'h00, 0, 0, 0, 0, 1, 0, 0);
    put(8'h11, 0); put(8'h22, 0); put(8'h33, 0); put(8'h44, 0); idle(3, 0);
    put(8'hA5, 0); put(8'h5A, 0); idle(T + 2, 0);
    put(8'hA5, 0); put(8'h5A, 0); idle(T - 1, 0); put(8'h3C, 0); idle(T + 2, 0);
    for (int i = 1; i <= 8; i++) put(8'(i), 1);
    idle(3, 1); idle(3, 0);
    step(0, 8'h00, 0, 0, 0, 0, 1, 1, 0); idle(2, 0);
    put(8'hDE, 0); put(8'hAD, 0);
    step(0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) put(8'(i), 0);
    idle(T + 2, 0);
    put(8'h10, 0); step(1, 8'h20, 1, 0, 0, 0, 1, 0, 0); put(8'h30, 0); put(8'h40, 0); put(8'h50, 0);
    idle(T + 2, 0);
    for (int i = 1; i <= 4; i++) put(8'(i), 1);
    step(0, 8'h00, 0, 0, 0, 1, 1, 0, 1);
    idle(3, 0);
    put(8'hC1, 0); put(8'hC2, 0); put(8'hC3, 0); put(8'hC4, 0); idle(2, 0);
    rf = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 20) == 0) rf = !rf;
      if ($urandom_range(0, 150) == 0) idle($urandom_range(T - 2, T + 2), rf);
      step($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0, rf, $urandom_range(0, 60) != 0, $urandom_range(0, 40) == 0,
           $urandom_range(0, 700) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
